cfg_loader: RTL and testbench
=============================

# cfg_loader

Configuration loader that writes the `cfg` bus consumed by a fabric tile's switch box and other configurable blocks. It accepts a word-serial bitstream over a valid/ready stream, assembles `CFG_SIZE` bits LSB-first, and presents them on `cfg`. Once its own tile is full, it forwards all further words unchanged to a downstream loader, so tiles can be daisy-chained from a single bitstream source.

## Interface
Parameters:
- `CFG_SIZE`, 256: width of the `cfg` output. Must be an integer multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 8: bitstream word width. Derived: `NWORDS = CFG_SIZE/WORD_WIDTH`; counter width is `$clog2(NWORDS)`, with a minimum of 1.

Ports:
- `clk`  in  1  single clock; all state is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse that begins a new load of this tile.
- `in_data`  in  WORD_WIDTH  bitstream word from upstream.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  word accepted when `in_valid & in_ready` at a rising edge.
- `out_data`  out  WORD_WIDTH  forwarded word to downstream.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the word.
- `cfg`  out  CFG_SIZE  configuration bits to the tile.
- `done`  out  1  one-cycle pulse; `cfg` holds a complete new image.
- `busy`  out  1  high in LOAD state.

## Operation
- States: IDLE, LOAD, PASS.
  - IDLE to LOAD on `load_start`.
  - LOAD to PASS when the word with index `NWORDS-1` is accepted.
  - PASS to LOAD on `load_start`.
  - LOAD on `load_start`: restarts the load. The counter returns to 0; already-written bits are not cleared.
- LOAD:
  - `in_ready = ~load_start`.
  - Accepted word k (k counts from 0) is written to bit slice `[k*WORD_WIDTH +: WORD_WIDTH]`.
  - The counter increments by 1 per accepted word.
  - `out_valid = 0`.
- PASS: combinational pass-through.
  - `out_data = in_data`.
  - `out_valid = in_valid & ~load_start`.
  - `in_ready = out_ready & ~load_start`.
  - `cfg` is unchanged.
- IDLE:
  - `in_ready = 0`, `out_valid = 0`.
  - `out_data` is don't-care, but driven to `in_data`.
- `load_start` in the same cycle as `in_valid`: `load_start` wins and no word is accepted that cycle.
- `busy` = (state == LOAD).
- `cfg` bits change only as described under Configuration.

## Timing
- Reset values while `rst_n` = 0, and immediately on its assertion:
  - state = IDLE, counter = 0.
  - `cfg` = 0, shadow = 0 (an all-zero cfg selects constant 0 at every switch-box mux).
  - `done` = 0, `busy` = 0, `in_ready` = 0, `out_valid` = 0.
- Reset mid-load: the partial image is discarded and `cfg` returns to 0.
- First word can be accepted in the cycle after `load_start`.
- Sustained throughput is 1 word/cycle.
- `done` is registered. It is high exactly one cycle: the cycle after the edge that accepts word `NWORDS-1`.
- `done` asserts in the same cycle `cfg` first shows the complete image.
- PASS path has zero latency (no registers).
- In PASS, `in_ready` depends combinationally on `out_ready`.

## Configuration
- Macro: `CFG_LOADER_SHADOW_EN`.
- Defined:
  - Words are written into an internal `CFG_SIZE` shadow register.
  - `cfg` is loaded from the shadow atomically at the edge after the last word is accepted.
  - During loading, or a restarted load, `cfg` holds the previous complete image; the tile never sees a partial configuration.
- Undefined:
  - No shadow. Words are written directly into `cfg` at the accepting edge.
  - `cfg` shows partial images during a load.
  - `done` timing is unchanged.

## Test plan
Use `CFG_SIZE`=32, `WORD_WIDTH`=8 for all scenarios.
- Reset then idle: assert `rst_n`=0 mid-stream, release → `cfg`=0, `in_ready`=0, `out_valid`=0, `done`=0. `in_valid`=1 held in IDLE → no words accepted.
- Full load: `load_start`, then words 0x11, 0x22, 0x33, 0x44 back-to-back → `cfg`=0x44332211. `done` high for one cycle, the cycle after the 0x44 edge. State PASS.
- Stalls: same load with `in_valid` toggling 1,0,1,0 → same `cfg`=0x44332211. `done` fires one cycle after the 4th accepted word.
- Pass-through with backpressure: after the full load, send 0xAA, 0xBB with `out_ready` low for 2 cycles → `in_ready`=0 while stalled. Downstream receives 0xAA then 0xBB. `cfg` is unchanged.
- Restart: after words 0x01, 0x02, pulse `load_start` with `in_valid`=1 (that word is not accepted), then send 0x55, 0x66, 0x77, 0x88 → `cfg`=0x88776655. With the macro, `cfg` keeps its previous value until commit; without it, `cfg`[15:0]=0x0201 is visible before the restart.
- Reset mid-load: assert `rst_n`=0 after 2 of 4 words → `cfg`=0, `busy`=0. Then a full load of 0xDEADBEEF (words EF, BE, AD, DE) → `cfg`=0xDEADBEEF.

Source files
------------

// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
//
// Word-serial configuration loader for one fabric tile. A load starts with a
// one-cycle load_start pulse. The next NWORDS words accepted on the in_* stream
// are assembled LSB-first into the CFG_SIZE-bit cfg image. Every word after
// that is forwarded unchanged and combinationally to the out_* stream, so
// several tiles can be daisy-chained from a single bitstream source.
//
// Optional feature (macro CFG_LOADER_SHADOW_EN):
//   defined   - words are collected in a shadow register. cfg is updated
//               atomically with the complete image, so the tile never sees
//               a partial configuration.
//   undefined - words are written straight into cfg. Partial images are
//               visible while a load is in progress.
//   done timing is the same in both builds.
//
// Parameters:
//   CFG_SIZE    width of cfg; must be an integer multiple of WORD_WIDTH
//   WORD_WIDTH  bitstream word width
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_start  one-cycle pulse that (re)starts a load of this tile
//   in_data     bitstream word from upstream
//   in_valid    in_data is valid
//   in_ready    word accepted when in_valid & in_ready at a rising edge
//   out_data    forwarded word to downstream
//   out_valid   out_data is valid
//   out_ready   downstream accepts the word
//   cfg         configuration image to the tile
//   done        one-cycle pulse; cfg holds a complete new image
//   busy        high while a load is in progress
// -----------------------------------------------------------------------------
module cfg_loader #(
    parameter int CFG_SIZE   = 256,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CFG_SIZE-1:0]   cfg,
    output logic                  done,
    output logic                  busy
);

    localparam int NWORDS = CFG_SIZE / WORD_WIDTH;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PASS = 2'd2
    } state_e;

    // Return img with word slot idx replaced by word; all other slots kept.
    function automatic logic [CFG_SIZE-1:0] merge_word(
        input logic [CFG_SIZE-1:0]   img,
        input logic [CNT_W-1:0]      idx,
        input logic [WORD_WIDTH-1:0] word
    );
        logic [CFG_SIZE-1:0] res;
        res = img;
        for (int w = 0; w < NWORDS; w++) begin
            res[w*WORD_WIDTH +: WORD_WIDTH] =
                (idx == CNT_W'(w)) ? word : img[w*WORD_WIDTH +: WORD_WIDTH];
        end
        return res;
    endfunction

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CFG_SIZE-1:0]  cfg_q;
    logic [CFG_SIZE-1:0]  cfg_d;
    logic                 done_q;
    logic                 done_d;
`ifdef CFG_LOADER_SHADOW_EN
    logic [CFG_SIZE-1:0]  shadow_q;
    logic [CFG_SIZE-1:0]  shadow_d;
`endif

    logic                 word_accept;
    logic                 last_word;

    // A word is taken only in LOAD. load_start has priority over the stream,
    // so no word is consumed in the cycle a load is (re)started.
    assign word_accept = (state_q == ST_LOAD) & in_valid & ~load_start;
    assign last_word   = word_accept & (cnt_q == LAST_IDX);

    // Handshake outputs; the PASS path is purely combinational (zero latency).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready  = ~load_start;
                out_valid = 1'b0;
            end
            ST_PASS: begin
                in_ready  = out_ready & ~load_start;
                out_valid = in_valid & ~load_start;
            end
            ST_IDLE: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Next-state, word counter and done pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (load_start) begin
            // Start or restart: already written bits are kept, only the
            // counter rewinds.
            state_d = ST_LOAD;
            cnt_d   = {CNT_W{1'b0}};
        end else if (last_word) begin
            state_d = ST_PASS;
            cnt_d   = {CNT_W{1'b0}};
            done_d  = 1'b1;
        end else if (word_accept) begin
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            cnt_d   = cnt_q;
        end
    end

`ifdef CFG_LOADER_SHADOW_EN
    // Collect words in the shadow; cfg takes the completed image at the edge
    // that accepts the final word, so it lines up with the done pulse.
    always_comb begin
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        if (word_accept) begin
            shadow_d = merge_word(shadow_q, cnt_q, in_data);
        end else begin
            shadow_d = shadow_q;
        end
        if (last_word) begin
            cfg_d = shadow_d;
        end else begin
            cfg_d = cfg_q;
        end
    end
`else
    // Write each accepted word straight into its cfg slot.
    always_comb begin
        cfg_d = cfg_q;
        if (word_accept) begin
            cfg_d = merge_word(cfg_q, cnt_q, in_data);
        end else begin
            cfg_d = cfg_q;
        end
    end
`endif

    // State registers; reset clears any partial or complete image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            cfg_q    <= {CFG_SIZE{1'b0}};
            done_q   <= 1'b0;
`ifdef CFG_LOADER_SHADOW_EN
            shadow_q <= {CFG_SIZE{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            done_q   <= done_d;
`ifdef CFG_LOADER_SHADOW_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    // Forwarded data is always the upstream word; out_valid qualifies it.
    assign out_data = in_data;
    assign cfg      = cfg_q;
    assign done     = done_q;
    assign busy     = (state_q == ST_LOAD);

endmodule

// File: tb/tb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader
//
// Directed bench for cfg_loader with CFG_SIZE=32, WORD_WIDTH=8. A cycle table
// of {inputs, expected outputs} covers idle, a full load, a stalled load and
// pass-through with backpressure. Hand-written sequences cover restart and
// reset in the middle of a load. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_cfg_loader;

    localparam int CFG_SIZE = 32;
    localparam int WW       = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_start;
    logic [WW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [WW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [CFG_SIZE-1:0] cfg;
    logic            done;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cfg_loader #(.CFG_SIZE(CFG_SIZE), .WORD_WIDTH(WW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg        (cfg),
        .done       (done),
        .busy       (busy)
    );

    typedef struct {
        logic          ls;
        logic          iv;
        logic [7:0]    id;
        logic          ordy;
        logic          e_irdy;
        logic          e_ovld;
        logic [7:0]    e_odata;
        logic          e_done;
        logic          e_busy;
        logic [31:0]   e_cfg;
    } vec_t;

    vec_t          vecs[$];
    logic [7:0]    rx[$];

    localparam logic [31:0] FULL1 = 32'h4433_2211;

    // Expected cfg differs between the shadowed and direct-write builds
    // only while a load is in flight.
    function automatic logic [31:0] pick(input logic [31:0] shadow_val,
                                         input logic [31:0] direct_val);
`ifdef CFG_LOADER_SHADOW_EN
        return shadow_val;
`else
        return direct_val;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ls, input logic iv, input logic [7:0] id,
                       input logic ordy, input logic e_irdy, input logic e_ovld,
                       input logic [7:0] e_odata, input logic e_done,
                       input logic e_busy, input logic [31:0] e_cfg);
        vec_t v;
        v.ls = ls; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_odata = e_odata;
        v.e_done = e_done; v.e_busy = e_busy; v.e_cfg = e_cfg;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the falling edge, then settle.
    task automatic step(input logic ls, input logic iv, input logic [7:0] id,
                        input logic ordy);
        @(negedge clk);
        load_start = ls;
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        out_ready  = 1'b1;

        // ---------------- reset values ----------------
        @(negedge clk);
        #1;
        check("rst cfg",       cfg,       32'h0);
        check("rst in_ready",  {31'd0, in_ready},  32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst done",      {31'd0, done},      32'd0);
        check("rst busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- cycle table ----------------
        //   ls iv  id     ordy irdy ovld odata  done busy cfg
        // idle with in_valid held: nothing accepted
        add(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        // start with in_valid high: word not taken
        add(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
        // full back-to-back load
        add(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, pick(32'h0, 32'h0000_0011));
        add(1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, pick(32'h0, 32'h0000_2211));
        add(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, pick(32'h0, 32'h0033_2211));
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, FULL1);
        // stalled load: in_valid toggles 1,0,1,0
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, FULL1);
        add(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, FULL1);
        // pass-through with out_ready low for 2 cycles
        add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, FULL1);
        add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, FULL1);
        add(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, FULL1);
        add(1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0, FULL1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, FULL1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ls, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            check($sformatf("v%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_irdy});
            check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ovld});
            check($sformatf("v%0d done", i),      {31'd0, done},      {31'd0, vecs[i].e_done});
            check($sformatf("v%0d busy", i),      {31'd0, busy},      {31'd0, vecs[i].e_busy});
            check($sformatf("v%0d cfg", i),       cfg,                vecs[i].e_cfg);
            if (vecs[i].e_ovld) begin
                check($sformatf("v%0d out_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_odata});
            end
            if (out_valid && out_ready) begin
                rx.push_back(out_data);
            end
        end

        // downstream sees exactly AA then BB
        check("rx count", rx.size(), 32'd2);
        check("rx word0", (rx.size() > 0) ? {24'd0, rx[0]} : 32'hFFFF_FFFF, 32'h0000_00AA);
        check("rx word1", (rx.size() > 1) ? {24'd0, rx[1]} : 32'hFFFF_FFFF, 32'h0000_00BB);

        // ---------------- restart mid-load ----------------
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h01, 1'b1);
        step(1'b0, 1'b1, 8'h02, 1'b1);
        step(1'b1, 1'b1, 8'h03, 1'b1);
        check("restart in_ready",  {31'd0, in_ready},  32'd0);
        check("restart out_valid", {31'd0, out_valid}, 32'd0);
        check("restart busy",      {31'd0, busy},      32'd1);
        check("restart partial cfg", cfg, pick(FULL1, 32'h4433_0201));
        step(1'b0, 1'b1, 8'h55, 1'b1);
        check("restart in_ready2", {31'd0, in_ready}, 32'd1);
        step(1'b0, 1'b1, 8'h66, 1'b1);
        // slot 0 overwritten by 55 and word 03 never landed in slot 2
        check("restart slot0 cfg", cfg, pick(FULL1, 32'h4433_0255));
        step(1'b0, 1'b1, 8'h77, 1'b1);
        step(1'b0, 1'b1, 8'h88, 1'b1);
        check("restart done early", {31'd0, done}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("restart done",  {31'd0, done}, 32'd1);
        check("restart cfg",   cfg, 32'h8877_6655);
        check("restart busy2", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("restart done off", {31'd0, done}, 32'd0);

        // load_start in PASS while in_valid is high: nothing forwarded
        step(1'b1, 1'b1, 8'hC3, 1'b1);
        check("pass ls out_valid", {31'd0, out_valid}, 32'd0);
        check("pass ls in_ready",  {31'd0, in_ready},  32'd0);

        // ---------------- reset mid-load ----------------
        step(1'b0, 1'b1, 8'h12, 1'b1);
        step(1'b0, 1'b1, 8'h34, 1'b1);
        step(1'b0, 1'b1, 8'h56, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst cfg",       cfg, 32'h0);
        check("mid rst busy",      {31'd0, busy},      32'd0);
        check("mid rst in_ready",  {31'd0, in_ready},  32'd0);
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst done",      {31'd0, done},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h77, 1'b1);
        check("post rst in_ready", {31'd0, in_ready}, 32'd0);
        check("post rst cfg",      cfg, 32'h0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'hEF, 1'b1);
        step(1'b0, 1'b1, 8'hBE, 1'b1);
        step(1'b0, 1'b1, 8'hAD, 1'b1);
        step(1'b0, 1'b1, 8'hDE, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("deadbeef done", {31'd0, done}, 32'd1);
        check("deadbeef cfg",  cfg, 32'hDEAD_BEEF);
        check("deadbeef busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
